game_move_sequencer: RTL

- Sequences every player action in the Sokoban core: move, undo and restart.
- Arbitrates between the three request sources, drives a one-op-at-a-time handshake to the map engine, and keeps an undo history LIFO.
- Issues single-cycle inc/dec/rst pulses to the step counter (modulo-255, synchronous reset).
- Sits between the keyboard/button decoder and the map engine plus step counter.

---
 rtl/game_pkg.sv | 33 +++
 rtl/game_undo_stack.sv | 57 +++++
 rtl/game_move_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared encodings for the Sokoban move sequencer and its undo history.
package game_pkg;

    // Operation requested from the map engine.
    typedef enum logic [1:0] {
        OP_MOVE   = 2'd0,
        OP_UNDO   = 2'd1,
        OP_RELOAD = 2'd2
    } map_op_e;

    // Player direction as decoded from the keyboard/buttons.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    // Sequencer states: one idle/arbitration state plus one wait per op.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MOVE_WAIT = 2'd1,
        ST_UNDO_WAIT = 2'd2,
        ST_RLD_WAIT  = 2'd3
    } state_e;

    // One undo history entry: the move direction and whether a box moved.
    typedef struct packed {
        logic pushed;
        dir_e dir;
    } hist_entry_t;

endpackage

// File: rtl/game_undo_stack.sv
// Undo history: ring-buffer LIFO with saturating count. When full, a push
// overwrites the oldest entry, so pops replay only the newest DEPTH moves.
module game_undo_stack
    import game_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          clr_i,
    input  hist_entry_t   push_data_i,
    output hist_entry_t   top_o,
    output logic [AW:0]   count_o
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] wp_q;
    logic [AW:0]   count_q;
    hist_entry_t   mem_q [DEPTH];
    logic [AW-1:0] rd_ptr;

    // The newest entry sits just below the write pointer (wraps mod DEPTH).
    assign rd_ptr  = wp_q - AW'(1);
    assign top_o   = mem_q[rd_ptr];
    assign count_o = count_q;

    // Pointer and count bookkeeping; clear has priority over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q    <= '0;
            count_q <= '0;
        end else if (clr_i) begin
            wp_q    <= '0;
            count_q <= '0;
        end else if (push_i) begin
            wp_q <= wp_q + AW'(1);
            if (count_q != FULL) begin
                count_q <= count_q + (AW+1)'(1);
            end
        end else if (pop_i && (count_q != '0)) begin
            wp_q    <= rd_ptr;
            count_q <= count_q - (AW+1)'(1);
        end
    end

    // Entry storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (push_i && !clr_i) begin
            mem_q[wp_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/game_move_sequencer.sv
// Player action sequencer: arbitrates restart/undo/move, runs one map-engine
// op at a time, keeps undo history and pulses the step counter.
module game_move_sequencer
    import game_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          move_req,
    input  logic [1:0]    move_dir,
    input  logic          undo_req,
    input  logic          restart_req,
    output logic          req_ready,
    output logic          map_go,
    output logic [1:0]    map_op,
    output logic [1:0]    map_dir,
    output logic          map_push,
    input  logic          map_done,
    input  logic          map_moved,
    input  logic          map_pushed,
    output logic          step_inc,
    output logic          step_dec,
    output logic          step_rst,
    output logic [AW:0]   hist_count
);

    state_e      state_q, state_d;
    logic        map_go_q, map_go_d;
    map_op_e     map_op_q, map_op_d;
    dir_e        map_dir_q, map_dir_d;
    logic        map_push_q, map_push_d;
    logic        step_inc_q, step_inc_d;
    logic        step_dec_q, step_dec_d;
    logic        step_rst_q, step_rst_d;

    logic        hist_push, hist_pop, hist_clr;
    hist_entry_t hist_top, hist_wdata;
    logic [AW:0] hist_cnt;

    // A completed move records the direction it was issued with.
    assign hist_wdata = '{pushed: map_pushed, dir: map_dir_q};

    game_undo_stack #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_hist (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (hist_push),
        .pop_i       (hist_pop),
        .clr_i       (hist_clr),
        .push_data_i (hist_wdata),
        .top_o       (hist_top),
        .count_o     (hist_cnt)
    );

    // State and registered outputs; reset abandons any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            map_go_q   <= 1'b0;
            map_op_q   <= OP_MOVE;
            map_dir_q  <= DIR_UP;
            map_push_q <= 1'b0;
            step_inc_q <= 1'b0;
            step_dec_q <= 1'b0;
            step_rst_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            map_go_q   <= map_go_d;
            map_op_q   <= map_op_d;
            map_dir_q  <= map_dir_d;
            map_push_q <= map_push_d;
            step_inc_q <= step_inc_d;
            step_dec_q <= step_dec_d;
            step_rst_q <= step_rst_d;
        end
    end

    // Fixed-priority arbitration in IDLE and completion handling in WAIT.
    always_comb begin
        state_d    = state_q;
        map_go_d   = 1'b0;
        map_op_d   = map_op_q;
        map_dir_d  = map_dir_q;
        map_push_d = map_push_q;
        step_inc_d = 1'b0;
        step_dec_d = 1'b0;
        step_rst_d = 1'b0;
        hist_push  = 1'b0;
        hist_pop   = 1'b0;
        hist_clr   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (restart_req) begin
                    state_d    = ST_RLD_WAIT;
                    map_go_d   = 1'b1;
                    map_op_d   = OP_RELOAD;
                    map_dir_d  = DIR_UP;
                    map_push_d = 1'b0;
                    step_rst_d = 1'b1;
                    hist_clr   = 1'b1;
                end else if (undo_req) begin
                    // Undo with empty history is swallowed; lower requests drop.
                    if (hist_cnt != '0) begin
                        state_d    = ST_UNDO_WAIT;
                        map_go_d   = 1'b1;
                        map_op_d   = OP_UNDO;
                        map_dir_d  = hist_top.dir;
                        map_push_d = hist_top.pushed;
                        hist_pop   = 1'b1;
                    end
                end else if (move_req) begin
                    state_d    = ST_MOVE_WAIT;
                    map_go_d   = 1'b1;
                    map_op_d   = OP_MOVE;
                    map_dir_d  = dir_e'(move_dir);
                    map_push_d = 1'b0;
                end
            end
            ST_MOVE_WAIT: begin
                if (map_done) begin
                    state_d = ST_IDLE;
                    if (map_moved) begin
                        hist_push  = 1'b1;
                        step_inc_d = 1'b1;
                    end
                end
            end
            ST_UNDO_WAIT: begin
                if (map_done) begin
                    state_d    = ST_IDLE;
                    step_dec_d = 1'b1;
                end
            end
            ST_RLD_WAIT: begin
                if (map_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign map_go     = map_go_q;
    assign map_op     = map_op_q;
    assign map_dir    = map_dir_q;
    assign map_push   = map_push_q;
    assign step_inc   = step_inc_q;
    assign step_dec   = step_dec_q;
    assign step_rst   = step_rst_q;
    assign hist_count = hist_cnt;

endmodule
